// File: rtl/down_count16_pkg.sv
// Shared constants for the down_count16 retry/timeout counter.
// Imported by the interface and the counter top.
package down_count16_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_MAX   = (1 << WIDTH_DEF) - 1;
  localparam int CNT_ZERO  = 0;

endpackage

// File: rtl/down_count16_if.sv
// Control/status bundle between the FSM controller (master) and the
// down-counter (slave).
interface down_count16_if
  import down_count16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             down_count16_load;
  logic [WIDTH-1:0] load_val;
  logic             down_count16_dec;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             borrow;

  modport master (
    output down_count16_load, load_val, down_count16_dec,
    input  q, zero, tc, borrow
  );

  modport slave (
    input  down_count16_load, load_val, down_count16_dec,
    output q, zero, tc, borrow
  );

endinterface

// File: rtl/down_count16_half_sub_diffbar.sv
// One bit of the ripple-borrow decrement chain: computes a - bin.
// The difference is produced inverted (diff_n).
module half_sub_diffbar (
  input  logic a,
  input  logic bin,
  output logic diff_n,
  output logic bout
);

  assign diff_n = ~(a ^ bin);
  assign bout   = ~a & bin;

endmodule

// File: rtl/down_count16.sv
// Loadable synchronous down-counter with zero detect, terminal-count and
// borrow pulses. Build option: DOWN_COUNT16_SAT_EN saturates at zero instead of wrapping.
module down_count16
  import down_count16_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic            clk,
  input logic            down_count16_init,
  down_count16_if.slave  cif
);

  logic [WIDTH-1:0] q_r;
  logic             zero_r;
  logic             tc_r;
  logic             borrow_r;

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bout;
  logic [WIDTH-1:0] diff_n;
  logic [WIDTH-1:0] dec_val;
  logic             underflow;

  logic [WIDTH-1:0] q_nxt;
  logic             zero_nxt;
  logic             tc_nxt;
  logic             borrow_nxt;

  // Underflow policy: hold at zero when saturating, otherwise wrap to all-ones.
  function automatic logic [WIDTH-1:0] underflow_fix(input logic [WIDTH-1:0] d,
                                                     input logic             uf);
`ifdef DOWN_COUNT16_SAT_EN
    return uf ? WIDTH'(CNT_ZERO) : d;
`else
    return uf ? {WIDTH{1'b1}} : d;
`endif
  endfunction

  // Borrow enters at the LSB with dec; a borrow out of the MSB means dec at zero.
  assign bin = {bout[WIDTH-2:0], cif.down_count16_dec};

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    half_sub_diffbar u_hs (
      .a      (q_r[i]),
      .bin    (bin[i]),
      .diff_n (diff_n[i]),
      .bout   (bout[i])
    );
  end

  assign dec_val   = ~diff_n;
  assign underflow = bout[WIDTH-1];

  always_comb begin
    q_nxt      = q_r;
    zero_nxt   = zero_r;
    tc_nxt     = 1'b0;
    borrow_nxt = 1'b0;
    if (cif.down_count16_load) begin
      q_nxt    = cif.load_val;
      zero_nxt = (cif.load_val == WIDTH'(CNT_ZERO));
    end else if (cif.down_count16_dec) begin
      q_nxt      = underflow_fix(dec_val, underflow);
      zero_nxt   = (q_nxt == WIDTH'(CNT_ZERO));
      tc_nxt     = (q_r == WIDTH'(1));
      borrow_nxt = underflow;
    end
  end

  always_ff @(posedge clk) begin
    if (down_count16_init) begin
      q_r      <= INIT_VAL;
      zero_r   <= (INIT_VAL == WIDTH'(CNT_ZERO));
      tc_r     <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      q_r      <= q_nxt;
      zero_r   <= zero_nxt;
      tc_r     <= tc_nxt;
      borrow_r <= borrow_nxt;
    end
  end

  assign cif.q      = q_r;
  assign cif.zero   = zero_r;
  assign cif.tc     = tc_r;
  assign cif.borrow = borrow_r;

endmodule

// File: tb/tb_down_count16.sv
// Self-checking bench for down_count16: vector table plus a long countdown
// sequence, with expected outputs queued at drive time and checked after the edge.
module tb_down_count16;
  import down_count16_pkg::*;

`ifdef DOWN_COUNT16_SAT_EN
  localparam logic [3:0] UF_Q = 4'd0;
  localparam logic       UF_Z = 1'b1;
`else
  localparam logic [3:0] UF_Q = 4'd15;
  localparam logic       UF_Z = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       init;
    logic       load;
    logic [3:0] lv;
    logic       dec;
    logic [3:0] eq;
    logic       ez;
    logic       etc;
    logic       eb;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] eq;
    logic       ez;
    logic       etc;
    logic       eb;
  } exp_t;

  logic clk = 1'b0;
  logic init;

  down_count16_if #(.WIDTH(4)) cif ();

  down_count16 #(.WIDTH(4), .INIT_VAL(4'd0)) dut (
    .clk               (clk),
    .down_count16_init (init),
    .cif               (cif)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(string name, logic i, logic l, logic [3:0] lv, logic d,
                              logic [3:0] eq, logic ez, logic etc, logic eb);
    vec_t v;
    v.name = name; v.init = i; v.load = l; v.lv = lv; v.dec = d;
    v.eq = eq; v.ez = ez; v.etc = etc; v.eb = eb;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    init                  = v.init;
    cif.down_count16_load = v.load;
    cif.load_val          = v.lv;
    cif.down_count16_dec  = v.dec;
    e.name = v.name; e.eq = v.eq; e.ez = v.ez; e.etc = v.etc; e.eb = v.eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing expected", v.name);
    end else begin
      got = sb.pop_front();
      if (cif.q !== got.eq || cif.zero !== got.ez || cif.tc !== got.etc || cif.borrow !== got.eb) begin
        n_fail++;
        $display("FAIL %s: got q=%0d zero=%b tc=%b borrow=%b, need q=%0d zero=%b tc=%b borrow=%b",
                 got.name, cif.q, cif.zero, cif.tc, cif.borrow, got.eq, got.ez, got.etc, got.eb);
      end
    end
  endtask

  initial begin
    init                  = 1'b0;
    cif.down_count16_load = 1'b0;
    cif.load_val          = '0;
    cif.down_count16_dec  = 1'b0;
    @(posedge clk);
    #1;

    //          name            init load lv  dec  q     zero tc  borrow
    tbl.push_back(mk("reset",         1, 0, 4'd0,  0, 4'd0,  1, 0, 0));
    tbl.push_back(mk("load9",         0, 1, 4'd9,  0, 4'd9,  0, 0, 0));
    tbl.push_back(mk("init_mid",      1, 0, 4'd0,  1, 4'd0,  1, 0, 0));
    tbl.push_back(mk("load3",         0, 1, 4'd3,  0, 4'd3,  0, 0, 0));
    tbl.push_back(mk("dec3to2",       0, 0, 4'd0,  1, 4'd2,  0, 0, 0));
    tbl.push_back(mk("dec2to1",       0, 0, 4'd0,  1, 4'd1,  0, 0, 0));
    tbl.push_back(mk("dec1to0_tc",    0, 0, 4'd0,  1, 4'd0,  1, 1, 0));
    tbl.push_back(mk("idle_tc_drop",  0, 0, 4'd0,  0, 4'd0,  1, 0, 0));
    tbl.push_back(mk("dec_at_zero",   0, 0, 4'd0,  1, UF_Q,  UF_Z, 0, 1));
    tbl.push_back(mk("idle_b_drop",   0, 0, 4'd6,  0, UF_Q,  UF_Z, 0, 0));
    tbl.push_back(mk("load5",         0, 1, 4'd5,  0, 4'd5,  0, 0, 0));
    tbl.push_back(mk("load_beats_dec",0, 1, 4'd12, 1, 4'd12, 0, 0, 0));
    tbl.push_back(mk("load7",         0, 1, 4'd7,  0, 4'd7,  0, 0, 0));
    tbl.push_back(mk("init_beats_all",1, 1, 4'd3,  1, 4'd0,  1, 0, 0));
    tbl.push_back(mk("load1",         0, 1, 4'd1,  0, 4'd1,  0, 0, 0));
    tbl.push_back(mk("load1_dec_no_tc",0,1, 4'd1,  1, 4'd1,  0, 0, 0));
    tbl.push_back(mk("hold",          0, 0, 4'd8,  0, 4'd1,  0, 0, 0));
    tbl.push_back(mk("load0_zero",    0, 1, 4'd0,  0, 4'd0,  1, 0, 0));
    tbl.push_back(mk("load10",        0, 1, 4'd10, 0, 4'd10, 0, 0, 0));
    tbl.push_back(mk("dec10to9",      0, 0, 4'd0,  1, 4'd9,  0, 0, 0));
    tbl.push_back(mk("dec9to8",       0, 0, 4'd0,  1, 4'd8,  0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Full countdown from 15: tc on reaching zero, borrow on the 16th dec.
    apply(mk("load15", 0, 1, 4'd15, 0, 4'd15, 0, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      if (k <= 15)
        apply(mk($sformatf("run_dec%0d", k), 0, 0, 4'd0, 1, 4'(15 - k),
                 (k == 15), (k == 15), 1'b0));
      else
        apply(mk("run_dec16_borrow", 0, 0, 4'd0, 1, UF_Q, UF_Z, 1'b0, 1'b1));
    end
    apply(mk("run_release", 0, 0, 4'd0, 0, UF_Q, UF_Z, 0, 0));

    // Borrow must not stretch under a continued dec after underflow.
`ifdef DOWN_COUNT16_SAT_EN
    apply(mk("sat_again", 0, 0, 4'd0, 1, 4'd0, 1, 0, 1));
`else
    apply(mk("wrap_dec15", 0, 0, 4'd0, 1, 4'd14, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
